// File: rtl/mmio_responder_if.sv
// mmio_responder_if: processor bus plus TX byte stream of the MMIO responder.
//   Processor side : adr, writedata, memwrite (in to responder),
//                    sel, readdata (out, combinational from adr).
//   TX stream      : tx_data, tx_valid (out), tx_ready (in).
// Handshake: a byte transfers on a rising clk edge where tx_valid & tx_ready
// are both high; while tx_valid is high and tx_ready is low, tx_data and
// tx_valid hold steady.
// The master modport is the system side: the CPU bus driver together with
// the console consumer that owns tx_ready.
interface mmio_responder_if;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memwrite;
    logic        sel;
    logic [31:0] readdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output adr, writedata, memwrite, tx_ready,
        input  sel, readdata, tx_data, tx_valid
    );

    modport slave (
        input  adr, writedata, memwrite, tx_ready,
        output sel, readdata, tx_data, tx_valid
    );
endinterface

// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped peripheral on the multicycle MIPS bus.
// Registers (16-byte window at BASE_ADDR):
//   0x0 TXDATA  read 0 / write pushes writedata[7:0] into the TX FIFO
//   0x4 STATUS  read {count[3:0], overflow, empty, full} in bits [6:0]
//               write: writedata[2]=1 clears the sticky overflow flag
//   0x8 CTRL    read/write irq_en in bit 0
//   0xC CYCLES  free-running cycle counter, writable
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    slave side of mmio_responder_if (processor bus + TX stream)
//   irq    TX-drained interrupt: irq_en & FIFO empty
module mmio_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 4   // power of 2, 2..16
) (
    input  logic                clk,
    input  logic                reset,
    mmio_responder_if.slave     bus,
    output logic                irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;             // count must reach FIFO_DEPTH
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] IDX_TXDATA = 2'd0;
    localparam logic [1:0] IDX_STATUS = 2'd1;
    localparam logic [1:0] IDX_CTRL   = 2'd2;
    localparam logic [1:0] IDX_CYCLES = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          irq_en;
    logic [31:0]   cycles;

    logic [1:0]    reg_idx;
    logic          wr;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push_req;
    logic          push_ok;
    logic [4:0]    count_ext;

    // ---------------- decode ----------------
    assign bus.sel  = (bus.adr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx  = bus.adr[3:2];
    assign wr       = bus.memwrite & bus.sel;

    // ---------------- FIFO control ----------------
    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign bus.tx_valid = !empty;
    assign bus.tx_data  = mem[rd_ptr];
    assign pop       = bus.tx_valid & bus.tx_ready;
    assign push_req  = wr & (reg_idx == IDX_TXDATA);
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is still accepted when the consumer is taking the head.
    assign push_ok   = push_req & (!full | pop);

    assign irq = irq_en & empty;

    // Storage has no reset: contents are meaningless while count is 0.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.writedata[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-2 depth: pointer overflow is the modulo wrap.
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (!push_ok && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // ---------------- status / control registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            irq_en   <= 1'b0;
        end else begin
            // Set and clear target different registers, so they never collide.
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (wr && (reg_idx == IDX_STATUS) && bus.writedata[2]) begin
                overflow <= 1'b0;
            end
            if (wr && (reg_idx == IDX_CTRL)) begin
                irq_en <= bus.writedata[0];
            end
        end
    end

    // Cycle counter: a load replaces the increment for that edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles <= '0;
        end else if (wr && (reg_idx == IDX_CYCLES)) begin
            cycles <= bus.writedata;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    // ---------------- read mux (side-effect free) ----------------
    assign count_ext = 5'(count);

    always_comb begin
        bus.readdata = 32'd0;
        if (bus.sel) begin
            case (reg_idx)
                IDX_TXDATA: bus.readdata = 32'd0;
                IDX_STATUS: bus.readdata = {25'd0, count_ext[3:0], overflow, empty, full};
                IDX_CTRL:   bus.readdata = {31'd0, irq_en};
                IDX_CYCLES: bus.readdata = cycles;
                default:    bus.readdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic clk;
    logic reset;
    logic irq;

    mmio_responder_if bus();

    mmio_responder #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Observe the stream 1 ns before each rising edge: a byte leaves on that edge.
    always @(negedge clk) begin
        #4;
        if (reset && bus.tx_valid && bus.tx_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {24'd0, bus.tx_data}, 32'hxxxx_xxxx);
            end else begin
                chk("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.adr       = a;
        bus.writedata = d;
        bus.memwrite  = 1'b1;
        @(negedge clk);
        bus.memwrite  = 1'b0;
    endtask

    task automatic rd_now(input logic [31:0] a, output logic [31:0] d);
        bus.adr = a;
        #1;
        d = bus.readdata;
    endtask

    // Wait (bounded) for the FIFO to empty; returns the number of negedges taken.
    task automatic wait_drain(input string name, output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            n++;
            if (!bus.tx_valid) break;
        end
        if (bus.tx_valid) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    // ---------------- decode vector table ----------------
    typedef struct {
        string       name;
        logic [31:0] adr;
        logic        exp_sel;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[7];

    logic [31:0] r;
    int          n;

    initial begin
        vecs[0] = '{"rd_txdata",     BASE + 32'h0,  1'b1, 32'h0};
        vecs[1] = '{"rd_status",     BASE + 32'h4,  1'b1, 32'h2};
        vecs[2] = '{"rd_status_lsb", BASE + 32'h7,  1'b1, 32'h2};
        vecs[3] = '{"rd_ctrl",       BASE + 32'h8,  1'b1, 32'h0};
        vecs[4] = '{"rd_above",      BASE + 32'h10, 1'b0, 32'h0};
        vecs[5] = '{"rd_below",      BASE - 32'h4,  1'b0, 32'h0};
        vecs[6] = '{"rd_zero",       32'h0,         1'b0, 32'h0};

        reset         = 1'b0;
        bus.adr       = 32'h0;
        bus.writedata = 32'h0;
        bus.memwrite  = 1'b0;
        bus.tx_ready  = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rd_now(BASE + 32'hC, r);
        chk("cycles_at_release", r, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rd_now(BASE + 32'hC, r);
        chk("cycles_plus2", r, 32'd2);

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.adr = vecs[i].adr;
            #1;
            chk({vecs[i].name, "_sel"}, {31'd0, bus.sel}, {31'd0, vecs[i].exp_sel});
            chk({vecs[i].name, "_data"}, bus.readdata, vecs[i].exp_rd);
        end
        chk("idle_irq", {31'd0, irq}, 32'd0);

        // ---- fill past full, then drain ----
        for (int b = 8'h41; b <= 8'h45; b++) begin
            sw(BASE, 32'(b));
            if (b <= 8'h44) exp_q.push_back(8'(b));
        end
        rd_now(BASE + 32'h4, r);
        chk("status_full_ovf", r, 32'h25);
        repeat (3) @(negedge clk);
        #1;
        chk("head_stable", {24'd0, bus.tx_data}, 32'h41);
        chk("valid_stable", {31'd0, bus.tx_valid}, 32'd1);
        bus.tx_ready = 1'b1;
        wait_drain("drain1", n);
        chk("drain1_cycles", 32'(n), 32'd4);
        bus.tx_ready = 1'b0;
        rd_now(BASE + 32'h4, r);
        chk("status_empty_ovf", r, 32'h06);

        // ---- clear overflow, then push+pop on a full FIFO ----
        sw(BASE + 32'h4, 32'h4);
        rd_now(BASE + 32'h4, r);
        chk("status_ovf_cleared", r, 32'h02);
        for (int b = 8'h10; b <= 8'h13; b++) begin
            sw(BASE, 32'(b));
            exp_q.push_back(8'(b));
        end
        @(negedge clk);
        bus.adr       = BASE;
        bus.writedata = 32'h55;
        bus.memwrite  = 1'b1;
        bus.tx_ready  = 1'b1;
        exp_q.push_back(8'h55);
        @(negedge clk);
        bus.memwrite  = 1'b0;
        bus.tx_ready  = 1'b0;
        rd_now(BASE + 32'h4, r);
        chk("status_push_pop_full", r, 32'h21);
        bus.tx_ready = 1'b1;
        wait_drain("drain2", n);
        chk("drain2_cycles", 32'(n), 32'd4);
        bus.tx_ready = 1'b0;
        chk("queue_empty_2", 32'(exp_q.size()), 32'd0);

        // ---- overflow clear with data held, irq on drain ----
        for (int b = 8'h60; b <= 8'h64; b++) begin
            sw(BASE, 32'(b));
            if (b <= 8'h63) exp_q.push_back(8'(b));
        end
        rd_now(BASE + 32'h4, r);
        chk("status_ovf_again", r, 32'h25);
        sw(BASE + 32'h4, 32'h4);
        rd_now(BASE + 32'h4, r);
        chk("status_ovf_clr_keep", r, 32'h21);
        sw(BASE + 32'h8, 32'h1);
        rd_now(BASE + 32'h8, r);
        chk("ctrl_irq_en", r, 32'h1);
        chk("irq_nonempty", {31'd0, irq}, 32'd0);
        bus.tx_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("irq_drain_%0d", k), {31'd0, irq}, {31'd0, (k >= 4)});
            chk($sformatf("valid_drain_%0d", k), {31'd0, bus.tx_valid}, {31'd0, (k < 4)});
        end
        bus.tx_ready = 1'b0;
        sw(BASE + 32'h8, 32'h0);
        #1;
        chk("irq_disabled", {31'd0, irq}, 32'd0);

        // ---- cycle counter load and wrap ----
        sw(BASE + 32'hC, 32'hFFFF_FFFE);
        rd_now(BASE + 32'hC, r);
        chk("cycles_load", r, 32'hFFFF_FFFE);
        @(negedge clk);
        rd_now(BASE + 32'hC, r);
        chk("cycles_max", r, 32'hFFFF_FFFF);
        @(negedge clk);
        rd_now(BASE + 32'hC, r);
        chk("cycles_wrap", r, 32'h0);

        // ---- reset mid-stream ----
        sw(BASE + 32'h8, 32'h1);
        for (int b = 8'h70; b <= 8'h72; b++) sw(BASE, 32'(b));
        @(negedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd_now(BASE + 32'hC, r);
        chk("post_rst_cycles", r, 32'd0);
        rd_now(BASE + 32'h4, r);
        chk("post_rst_status", r, 32'h02);
        rd_now(BASE + 32'h8, r);
        chk("post_rst_ctrl", r, 32'h0);

        // ---- write outside the region ----
        sw(BASE + 32'h10, 32'h77);
        rd_now(BASE + 32'h10, r);
        chk("outside_sel", {31'd0, bus.sel}, 32'd0);
        chk("outside_data", r, 32'h0);
        rd_now(BASE + 32'h4, r);
        chk("outside_no_push", r, 32'h02);
        chk("outside_no_valid", {31'd0, bus.tx_valid}, 32'd0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
